// File: rtl/grid_env_step.sv
// Registered grid-world step unit: (state, action) in, next state / reward / done out one cycle later.
// Define OBSTACLE_EN to add the i_obstacle_map input that marks blocked cells.
module grid_env_step #(
  parameter int GRID_W        = 5,
  parameter int GRID_H        = 5,
  parameter int STATES_WIDTH  = 5,
  parameter int ACTIONS_WIDTH = 2,
  parameter int GOAL_STATE    = 24,
  parameter int MAX_STEPS     = 64,
  parameter int REWARD_WIDTH  = 8,
  parameter int R_GOAL        = 10,
  parameter int R_STEP        = -1,
  parameter int R_WALL        = -5,
  localparam int CNT_W        = $clog2(MAX_STEPS + 1)
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_valid,
  output logic                           o_ready,
  input  logic [STATES_WIDTH-1:0]        i_st,
  input  logic [ACTIONS_WIDTH-1:0]       i_at,
  output logic                           o_valid,
  input  logic                           i_ready,
`ifdef OBSTACLE_EN
  input  logic [GRID_W*GRID_H-1:0]       i_obstacle_map,
`endif
  output logic [STATES_WIDTH-1:0]        o_next_st,
  output logic signed [REWARD_WIDTH-1:0] o_reward,
  output logic                           o_done,
  output logic                           o_timeout,
  output logic [CNT_W-1:0]               o_step_cnt
);

  localparam int NCELLS = GRID_W * GRID_H;
  localparam logic [STATES_WIDTH-1:0] W_S    = STATES_WIDTH'(GRID_W);
  localparam logic [STATES_WIDTH-1:0] W_LAST = STATES_WIDTH'(GRID_W - 1);
  localparam logic [STATES_WIDTH-1:0] H_LAST = STATES_WIDTH'(GRID_H - 1);
  localparam logic [STATES_WIDTH-1:0] GOAL_S = STATES_WIDTH'(GOAL_STATE);
  localparam logic [CNT_W-1:0]        MAX_C  = CNT_W'(MAX_STEPS);
  localparam logic signed [REWARD_WIDTH-1:0] RW_GOAL = REWARD_WIDTH'(R_GOAL);
  localparam logic signed [REWARD_WIDTH-1:0] RW_STEP = REWARD_WIDTH'(R_STEP);
  localparam logic signed [REWARD_WIDTH-1:0] RW_WALL = REWARD_WIDTH'(R_WALL);

  typedef enum logic {EMPTY, FULL} state_e;

  state_e                          state_q, state_d;
  logic [STATES_WIDTH-1:0]         next_st_q, next_st_d;
  logic signed [REWARD_WIDTH-1:0]  reward_q, reward_d;
  logic                            done_q, done_d;
  logic                            timeout_q, timeout_d;
  logic [CNT_W-1:0]                step_cnt_q, cnt_q, cnt_d;

  logic                            accept;
  logic                            in_range, blocked, goal_hit;
  logic [STATES_WIDTH-1:0]         row, col, tgt;

  assign o_valid    = (state_q == FULL);
  assign o_ready    = !o_valid || i_ready;
  assign accept     = i_valid && o_ready;
  assign o_next_st  = next_st_q;
  assign o_reward   = reward_q;
  assign o_done     = done_q;
  assign o_timeout  = timeout_q;
  assign o_step_cnt = step_cnt_q;

  assign in_range = (32'(i_st) < NCELLS);
  assign row      = i_st / W_S;
  assign col      = i_st % W_S;

  // Move target: a blocked move leaves the state where it is, it never wraps.
  always_comb begin
    blocked = 1'b0;
    tgt     = i_st;
    case (i_at)
      ACTIONS_WIDTH'(0): if (row != '0)    tgt = i_st - W_S; else blocked = 1'b1;
      ACTIONS_WIDTH'(1): if (row < H_LAST) tgt = i_st + W_S; else blocked = 1'b1;
      ACTIONS_WIDTH'(2): if (col < W_LAST) tgt = i_st + STATES_WIDTH'(1); else blocked = 1'b1;
      default:           if (col != '0)    tgt = i_st - STATES_WIDTH'(1); else blocked = 1'b1;
    endcase
`ifdef OBSTACLE_EN
    if (!blocked && (tgt != GOAL_S) && i_obstacle_map[tgt]) begin
      blocked = 1'b1;
      tgt     = i_st;
    end
`endif
  end

  always_comb begin
    cnt_d     = cnt_q + CNT_W'(1);
    goal_hit  = 1'b0;
    next_st_d = '0;
    reward_d  = RW_WALL;
    done_d    = 1'b1;
    timeout_d = 1'b0;
    if (in_range) begin
      goal_hit  = (tgt == GOAL_S);
      next_st_d = tgt;
      reward_d  = goal_hit ? RW_GOAL : (blocked ? RW_WALL : RW_STEP);
      timeout_d = !goal_hit && (cnt_d == MAX_C);
      done_d    = goal_hit || timeout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (accept) state_d = FULL;
      FULL:    if (i_ready && !accept) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  // The internal counter restarts after any episode-ending result; the presented count keeps its final value.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= EMPTY;
      next_st_q  <= '0;
      reward_q   <= '0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
      step_cnt_q <= '0;
      cnt_q      <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        next_st_q  <= next_st_d;
        reward_q   <= reward_d;
        done_q     <= done_d;
        timeout_q  <= timeout_d;
        step_cnt_q <= cnt_d;
        cnt_q      <= done_d ? '0 : cnt_d;
      end
    end
  end

endmodule

// File: doc/grid_env_step.md
# grid_env_step

Registered, parametrised grid-world environment step unit for the Q-learning datapath. It accepts a (state, action) request through a valid/ready handshake and returns the next state, a signed reward and an episode-done flag one cycle later. It also keeps an episode step counter with timeout. It sits between the action-selection stage and the Q-table update stage and replaces the combinational next-state logic.

## Interface
- GRID_W, 5: grid columns (≥2)
- GRID_H, 5: grid rows (≥2)
- STATES_WIDTH, 5: state index width, ≥ clog2(GRID_W*GRID_H)
- ACTIONS_WIDTH, 2: action width; 00 Up, 01 Down, 10 Right, 11 Left
- GOAL_STATE, 24: terminal cell index
- MAX_STEPS, 64: step limit per episode (≥1)
- REWARD_WIDTH, 8: signed reward width
- R_GOAL, 10 / R_STEP, -1 / R_WALL, -5: reward constants, two's complement in REWARD_WIDTH
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  reset, asynchronous assert, active-low
- i_valid  in  1  request valid
- o_ready  out  1  request accepted when i_valid && o_ready
- i_st  in  STATES_WIDTH  current state
- i_at  in  ACTIONS_WIDTH  action
- o_valid  out  1  result valid
- i_ready  in  1  downstream accepts result
- o_next_st  out  STATES_WIDTH  next state
- o_reward  out  REWARD_WIDTH  signed reward
- o_done  out  1  episode ended (goal or timeout)
- o_timeout  out  1  episode ended by step limit, not by goal
- o_step_cnt  out  clog2(MAX_STEPS+1)  steps accepted in the current episode

## Operation
- Two-state output FSM. EMPTY has o_valid=0. FULL has o_valid=1.
- o_ready = !o_valid || i_ready. A new result may load in the same cycle the old one drains.
- EMPTY→FULL on accept. FULL→EMPTY on i_ready with no accept. FULL→FULL on i_ready with accept, or when i_ready=0 (result held).
- Geometry: row = i_st / GRID_W, col = i_st % GRID_W.
- Up: row>0 → i_st−GRID_W. Down: row<GRID_H−1 → i_st+GRID_W. Right: col<GRID_W−1 → i_st+1. Left: col>0 → i_st−1.
- A blocked move at any edge, including the left edge, keeps the state unchanged. It never wraps or jumps to 0.
- Reward priority:
  - next state == GOAL_STATE → R_GOAL
  - move blocked → R_WALL
  - otherwise → R_STEP
- Out-of-range i_st (≥ GRID_W*GRID_H): o_next_st=0, reward R_WALL, o_done=1, o_timeout=0.
- Step counter:
  - On accept, the counter becomes cnt+1 and is presented on o_step_cnt with the result.
  - goal: o_done=1, o_timeout=0.
  - else cnt+1 == MAX_STEPS: o_done=1, o_timeout=1.
  - When the accepted result has o_done=1, the internal counter clears to 0 so the next accept starts a new episode. o_step_cnt in the held result keeps the final count.
- A request starting at GOAL_STATE is processed normally; moving away from the goal gives R_STEP.

## Timing
- Latency is 1 cycle: accept at edge N, result valid after edge N.
- Throughput is 1 request per cycle when i_ready=1.
- While o_valid && !i_ready, all outputs are stable and o_ready=0.
- Reset (async, any time, including mid-episode or while holding a result): o_valid=0, o_next_st=0, o_reward=0, o_done=0, o_timeout=0, o_step_cnt=0, internal counter=0, o_ready=1 after release.
- i_st and i_at are sampled only on accept.

## Configuration
- OBSTACLE_EN defined: adds input i_obstacle_map [GRID_W*GRID_H−1:0]. Bit k=1 marks cell k blocked.
  - A move whose target is an obstacle is treated as blocked: state unchanged, R_WALL.
  - The map is sampled on accept.
  - GOAL_STATE's bit is ignored.
- OBSTACLE_EN undefined: port absent; only grid edges block.

## Test plan
- Reset mid-hold: assert i_rst_n=0 while o_valid=1 → all outputs 0 immediately; after release o_ready=1 and o_step_cnt=0.
- Interior moves, 5×5 grid: st=12 Up → 7, reward −1, one cycle later; st=12 Left → 11; st=12 Down → 17; st=12 Right → 13.
- Edges: st=4 Right → 4, reward −5; st=20 Left → 20, reward −5 (not 0); st=22 Down → 22; st=2 Up → 2.
- Goal: st=19 Down → 24, reward +10, o_done=1, o_timeout=0; next accept reports o_step_cnt=1.
- Backpressure and throughput: hold i_ready=0 for 3 cycles → result stable, o_ready=0, no second accept; release → back-to-back requests produce one result per cycle.
- Timeout with MAX_STEPS=4: four non-goal steps → fourth has o_done=1, o_timeout=1, o_step_cnt=4; fifth step reports o_step_cnt=1. With OBSTACLE_EN and bit 13 set: st=12 Right → 12, reward −5.
